// File: rtl/tick_timer_pkg.sv
// Shared types and the round-robin pick helper for the tick timer scheduler.
package tick_timer_pkg;

  localparam int NCH_DEFAULT = 4;
  localparam int CW_DEFAULT  = 16;
  localparam int MAX_NCH     = 16;

  typedef logic [CW_DEFAULT-1:0] cnt_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } pick_t;

  // First set bit of eligible at or after ptr, wrapping within the low n bits.
  function automatic pick_t rr_pick(input logic [MAX_NCH-1:0] eligible,
                                    input logic [3:0]         ptr,
                                    input int unsigned        n);
    pick_t       p;
    int unsigned j;
    p = '0;
    for (int unsigned k = 0; k < MAX_NCH; k++) begin
      if (k < n && !p.valid) begin
        j = (32'(ptr) + k) % n;
        if (eligible[j[3:0]]) begin
          p.valid = 1'b1;
          p.idx   = j[3:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/tick_timer_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past each winner.
module rr_arbiter
  import tick_timer_pkg::*;
#(
  parameter int NCH = NCH_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] eligible,
  output logic [NCH-1:0] grant
);

  logic [3:0]         r_ptr;
  logic [MAX_NCH-1:0] w_elig;
  pick_t              w_pick;

  always_comb begin
    w_elig          = '0;
    w_elig[NCH-1:0] = eligible;
  end

  assign w_pick = rr_pick(w_elig, r_ptr, NCH);

  always_comb begin
    grant = '0;
    for (int i = 0; i < NCH; i++) begin
      grant[i] = w_pick.valid && (w_pick.idx == 4'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_pick.valid) begin
      r_ptr <= (w_pick.idx == 4'(NCH - 1)) ? 4'd0 : w_pick.idx + 4'd1;
    end
  end

endmodule

// File: rtl/tick_timer_scheduler.sv
// Multi-channel countdown timers sharing one tick prescaler and a round-robin load port.
// Define PERIODIC_RELOAD_EN to make armed channels reload their duration on expiry.
module tick_timer_scheduler
  import tick_timer_pkg::*;
#(
  parameter int NCH = NCH_DEFAULT,
  parameter int DIV = 100000,
  parameter int CW  = CW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pause,
  input  logic [NCH-1:0]    req,
  input  logic [NCH*CW-1:0] dur,
  input  logic [NCH-1:0]    cancel,
  output logic [NCH-1:0]    ack,
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    expire,
  output logic              tick
);

  localparam int PW = $clog2(DIV);

  logic [PW-1:0]  r_pre;
  logic           w_wrap;
  logic [NCH-1:0] r_ack;
  logic [NCH-1:0] w_elig;
  logic [NCH-1:0] w_grant;

  assign w_wrap = (r_pre == PW'(DIV - 1));
  assign tick   = w_wrap && !pause;
  assign ack    = r_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pre <= '0;
    end else if (!pause) begin
      r_pre <= w_wrap ? '0 : r_pre + PW'(1);
    end
  end

  // Handshake: a requester holds req (and a stable dur) until it sees ack, then drops req
  // that same cycle. ack is a one-cycle registered pulse; a channel whose ack is high, or
  // whose cancel is high, is not eligible, so a held req is never granted twice in a row.
  assign w_elig = req & ~r_ack & ~cancel;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .eligible (w_elig),
    .grant    (w_grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack <= '0;
    end else begin
      r_ack <= w_grant;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_exp;
    logic [CW-1:0] w_dur;
`ifdef PERIODIC_RELOAD_EN
    logic [CW-1:0] r_reload;
`endif

    assign w_dur      = dur[gi*CW +: CW];
    assign busy[gi]   = r_busy;
    assign expire[gi] = r_exp;

    // Priority: a load beats a cancel-free tick, and cancel beats expiry.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt    <= '0;
        r_busy   <= 1'b0;
        r_exp    <= 1'b0;
`ifdef PERIODIC_RELOAD_EN
        r_reload <= '0;
`endif
      end else if (w_grant[gi]) begin
        r_cnt    <= w_dur;
        r_busy   <= (w_dur != '0);
        r_exp    <= (w_dur == '0);
`ifdef PERIODIC_RELOAD_EN
        r_reload <= w_dur;
`endif
      end else if (cancel[gi]) begin
        r_cnt  <= '0;
        r_busy <= 1'b0;
        r_exp  <= 1'b0;
      end else if (tick && r_busy) begin
        if (r_cnt > CW'(1)) begin
          r_cnt <= r_cnt - CW'(1);
          r_exp <= 1'b0;
        end else begin
          r_exp <= 1'b1;
`ifdef PERIODIC_RELOAD_EN
          r_cnt <= r_reload;
`else
          r_cnt  <= '0;
          r_busy <= 1'b0;
`endif
        end
      end else begin
        r_exp <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tick_timer_scheduler.sv
// Scoreboard bench for tick_timer_scheduler: directed scenarios then randomized traffic.
module tb_tick_timer_scheduler;

  localparam int NCH = 4;
  localparam int DIV = 4;
  localparam int CW  = 8;
  localparam int W   = 32 + 3 * NCH;

  // clock / reset
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pause = 1'b0;
  logic [NCH-1:0]    req = '0;
  logic [NCH-1:0]    cancel = '0;
  logic [NCH*CW-1:0] dur = '0;
  logic [NCH-1:0]    ack, busy, expire;
  logic              tick;

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  tick_timer_scheduler #(.NCH(NCH), .DIV(DIV), .CW(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .pause  (pause),
    .req    (req),
    .dur    (dur),
    .cancel (cancel),
    .ack    (ack),
    .busy   (busy),
    .expire (expire),
    .tick   (tick)
  );

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  // stimulus state
  logic [NCH-1:0] req_r = '0;
  logic [NCH-1:0] can_r = '0;
  logic           pause_r = 1'b0;
  logic [CW-1:0]  dur_r[NCH];

  // reference model: remaining ticks per channel, unpaused cycle count, rr pointer
  int             m_run;
  int             m_ptr;
  logic [NCH-1:0] m_ack;
  logic [NCH-1:0] m_armed;
  int             m_rem[NCH];
  int             m_per[NCH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_n, act, want);
    end
  endtask

  task automatic model_reset();
    m_run   = 0;
    m_ptr   = 0;
    m_ack   = '0;
    m_armed = '0;
    for (int i = 0; i < NCH; i++) begin
      m_rem[i] = 0;
      m_per[i] = 0;
    end
  endtask

  function automatic logic model_tick();
    return !pause_r && (m_run % DIV == DIV - 1);
  endfunction

  // Predict what the coming clock edge produces from the inputs now on the pins.
  task automatic model_step();
    logic           tick_now;
    logic [NCH-1:0] elig, new_ack, exp_v;
    int             g;
    tick_now = model_tick();
    elig     = req_r & ~m_ack & ~can_r;
    g        = -1;
    for (int k = 0; k < NCH; k++) begin
      if (g < 0 && elig[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
    end
    new_ack = '0;
    exp_v   = '0;
    for (int c = 0; c < NCH; c++) begin
      if (c == g) begin
        m_rem[c]   = int'(dur_r[c]);
        m_per[c]   = m_rem[c];
        m_armed[c] = (m_rem[c] != 0);
        exp_v[c]   = (m_rem[c] == 0);
      end else if (can_r[c]) begin
        m_armed[c] = 1'b0;
        m_rem[c]   = 0;
      end else if (tick_now && m_armed[c]) begin
        m_rem[c] = m_rem[c] - 1;
        if (m_rem[c] == 0) begin
          exp_v[c] = 1'b1;
`ifdef PERIODIC_RELOAD_EN
          m_rem[c] = m_per[c];
`else
          m_armed[c] = 1'b0;
`endif
        end
      end
    end
    if (g >= 0) begin
      new_ack[g] = 1'b1;
      m_ptr      = (g + 1) % NCH;
    end
    if (!pause_r) m_run++;
    m_ack = new_ack;
    if ((new_ack | exp_v) != '0) exp_q.push_back({32'(edge_n + 1), new_ack, exp_v, m_armed});
  endtask

  // driver: called at a falling edge
  task automatic body();
    for (int i = 0; i < NCH; i++) begin
      if (req_r[i] && m_ack[i]) req_r[i] = 1'b0;
    end
    req    = req_r;
    cancel = can_r;
    pause  = pause_r;
    for (int i = 0; i < NCH; i++) dur[i*CW +: CW] = dur_r[i];
    #1;
    check("tick", 32'(tick), 32'(model_tick()));
    check("busy", 32'(busy), 32'(m_armed));
    model_step();
    can_r = '0;
  endtask

  task automatic step();
    @(negedge clk);
    body();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("reset_outputs", 32'({ack, busy, expire, tick}), 32'd0);
    model_reset();
    repeat (n) @(negedge clk);
    rst = 1'b0;
    model_reset();
    body();
  endtask

  // monitor: compares every cycle where the DUT or the model shows an ack/expire event
  initial begin
    logic [W-1:0] got, e;
    logic         has_dut, has_exp;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        has_dut = (ack | expire) != '0;
        has_exp = (exp_q.size() > 0) && (exp_q[0][W-1 -: 32] == 32'(edge_n));
        if (has_dut || has_exp) begin
          got = {32'(edge_n), ack, expire, busy};
          e   = has_exp ? exp_q.pop_front() : '0;
          n_tests++;
          if (!has_exp || got !== e) begin
            n_fail++;
            $display("FAIL event @edge %0d: got ack/exp/busy %h expected %h", edge_n, got[3*NCH-1:0],
                     e[3*NCH-1:0]);
          end
        end
      end
    end
  end

  initial begin
    bit done;
    for (int i = 0; i < NCH; i++) dur_r[i] = '0;
    model_reset();

    // idle ticks after release
    do_reset(3);
    repeat (12) step();

    // single arm
    req_r[1] = 1'b1; dur_r[1] = 8'd3;
    repeat (18) step();

    // all four requesters from a fresh pointer
    do_reset(2);
    for (int i = 0; i < NCH; i++) begin
      req_r[i] = 1'b1;
      dur_r[i] = 8'd2;
    end
    repeat (14) step();

    // pause across two tick periods
    req_r[2] = 1'b1; dur_r[2] = 8'd5;
    repeat (3) step();
    pause_r = 1'b1;
    repeat (2 * DIV) step();
    pause_r = 1'b0;
    repeat (26) step();

    // cancel on the expiring edge
    req_r[0] = 1'b1; dur_r[0] = 8'd2;
    step();
    for (int k = 0; k < 20; k++) begin
      if (m_armed[0] && m_rem[0] == 1 && model_tick()) can_r[0] = 1'b1;
      step();
    end

    // zero-duration load
    req_r[3] = 1'b1; dur_r[3] = 8'd0;
    repeat (4) step();

    // re-arm on a tick edge
    req_r[1] = 1'b1; dur_r[1] = 8'd3;
    repeat (3) step();
    done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (!done && m_armed[1] && !req_r[1] && m_ack == '0 && model_tick()) begin
        req_r[1] = 1'b1;
        dur_r[1] = 8'd5;
        done     = 1'b1;
      end
      step();
    end
    repeat (30) step();

    // reset mid-operation with a request still held
    req_r[0] = 1'b1; dur_r[0] = 8'd6;
    step();
    do_reset(2);
    repeat (20) step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!req_r[i] && $urandom_range(0, 7) == 0) begin
          req_r[i] = 1'b1;
          dur_r[i] = ($urandom_range(0, 9) == 0) ? 8'd0 : CW'($urandom_range(1, 9));
        end
        can_r[i] = ($urandom_range(0, 29) == 0);
      end
      if ($urandom_range(0, 49) == 0) pause_r = !pause_r;
      step();
    end

    pause_r = 1'b0;
    req_r   = '0;
    repeat (10) step();
    @(posedge clk);
    #2;
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
